ps2_tx_arbiter: RTL and testbench

- Shares the single PS/2 transmit FIFO (byte strobe + fifo-ready flag) between two packet sources: keyboard (port 0) and mouse (port 1).
- Each source offers a whole packet of 1-4 bytes. The arbiter grants one source round-robin and pushes the packet's bytes back-to-back, so packets never interleave.
- Optional idle gap between packets.
- Sits between the keyboard/mouse scan logic and the PS/2 serialiser's tx_strobe/tx_byte/fifo_ready interface.

---
 rtl/ps2_tx_arbiter_pkg.sv | 24 ++
 rtl/ps2_tx_arbiter_if.sv | 22 ++
 rtl/ps2_tx_arbiter_rr_pick2.sv | 22 ++
 rtl/ps2_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_ps2_tx_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_tx_arbiter_pkg.sv
// Shared types and constants for the PS/2 transmit arbiter.
// Packets are 1-4 bytes; longer lengths are clamped.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } ps2_state_e;

  localparam int PS2_MAX_PKT = 4;

  localparam logic SRC_KBD   = 1'b0;
  localparam logic SRC_MOUSE = 1'b1;

  function automatic logic [2:0] clamp_len(
    input logic [2:0] l
  );
    if (l > 3'(PS2_MAX_PKT))
      return 3'(PS2_MAX_PKT);
    return l;
  endfunction

endpackage

// File: rtl/ps2_tx_arbiter_if.sv
// Packet source handshake: whole packet offered,
// held until the one-cycle ack.
interface ps2_tx_arbiter_if;
  logic        valid;
  logic [2:0]  len;
  logic [31:0] data;
  logic        ack;

  modport master (
    output valid,
    output len,
    output data,
    input  ack
  );

  modport slave (
    input  valid,
    input  len,
    input  data,
    output ack
  );
endinterface

// File: rtl/ps2_tx_arbiter_rr_pick2.sv
// Two-way round-robin picker; on a tie the source
// that did not win last time is chosen.
module ps2_rr_pick2
  import ps2_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       win,
  output logic       any
);

  always_comb begin
    any = |valid;
    win = SRC_KBD;
    case (valid)
      2'b11:   win = ~last;
      2'b10:   win = SRC_MOUSE;
      default: win = SRC_KBD;
    endcase
  end

endmodule

// File: rtl/ps2_tx_arbiter.sv
// Round-robin packet arbiter in front of the PS/2
// serialiser FIFO; packets are sent back-to-back.
module ps2_tx_arbiter
  import ps2_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_BITS   = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             enable,
  ps2_tx_arbiter_if.slave  kbd,
  ps2_tx_arbiter_if.slave  mouse,
  input  logic             ps2_fifo_ready,
  output logic             ps2_tx_strobe,
  output logic [7:0]       ps2_tx_byte,
  output logic             busy,
  output logic             grant
);

  ps2_state_e state_q, state_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  byte_q, byte_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;

  logic        win, any, take;
  logic [2:0]  eff_len;
  logic [31:0] win_data;
  logic [7:0]  cur_byte;
  ps2_state_e  after_pkt;

  ps2_rr_pick2 u_pick (
    .valid ({mouse.valid, kbd.valid}),
    .last  (last_q),
    .win   (win),
    .any   (any)
  );

  assign take = (state_q == ST_IDLE) && enable
             && ps2_fifo_ready && any;

  assign kbd.ack   = take && (win == SRC_KBD);
  assign mouse.ack = take && (win == SRC_MOUSE);

  assign eff_len  = clamp_len(win ? mouse.len
                                  : kbd.len);
  assign win_data = win ? mouse.data : kbd.data;
  assign cur_byte = data_q[{idx_q, 3'b000} +: 8];

  assign after_pkt = (GAP_CYCLES > 0) ? ST_GAP
                                      : ST_IDLE;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          len_d   = eff_len;
          data_d  = win_data;
          grant_d = win;
          last_d  = win;
          idx_d   = '0;
          gap_d   = '0;
          state_d = (eff_len != 3'd0) ? ST_SEND
                                      : after_pkt;
        end
      end
      ST_SEND: begin
        byte_d = cur_byte;
        idx_d  = idx_q + 2'd1;
        if ({1'b0, idx_q} == len_q - 3'd1) begin
          state_d = after_pkt;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_BITS'(GAP_CYCLES - 1))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      byte_q  <= '0;
      grant_q <= SRC_KBD;
      last_q  <= SRC_MOUSE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  // byte output follows the FIFO word while sending,
  // otherwise holds the last byte written
  assign ps2_tx_strobe = (state_q == ST_SEND);
  assign ps2_tx_byte   = ps2_tx_strobe ? cur_byte
                                       : byte_q;
  assign busy  = (state_q != ST_IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_ps2_tx_arbiter.sv
// Self-checking bench: vector table, directed corner
// sequences and a randomised queue-based reference.
module tb_ps2_tx_arbiter;

  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic rdy = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ps2_tx_arbiter_if k0 ();
  ps2_tx_arbiter_if m0 ();
  ps2_tx_arbiter_if k3 ();
  ps2_tx_arbiter_if m3 ();

  logic       stb0, busy0, gnt0;
  logic [7:0] byt0;
  logic       stb3, busy3, gnt3;
  logic [7:0] byt3;

  ps2_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
    .clk_sys        (clk_sys),
    .reset          (rst),
    .enable         (en),
    .kbd            (k0.slave),
    .mouse          (m0.slave),
    .ps2_fifo_ready (rdy),
    .ps2_tx_strobe  (stb0),
    .ps2_tx_byte    (byt0),
    .busy           (busy0),
    .grant          (gnt0)
  );

  ps2_tx_arbiter #(.GAP_CYCLES(3)) dut3 (
    .clk_sys        (clk_sys),
    .reset          (rst),
    .enable         (en),
    .kbd            (k3.slave),
    .mouse          (m3.slave),
    .ps2_fifo_ready (rdy),
    .ps2_tx_strobe  (stb3),
    .ps2_tx_byte    (byt3),
    .busy           (busy3),
    .grant          (gnt3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // inputs change just after the rising edge,
  // outputs are sampled on the falling edge
  task automatic nxt();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic idle_inputs();
    k0.valid = 0; k0.len = 0; k0.data = 0;
    m0.valid = 0; m0.len = 0; m0.data = 0;
    k3.valid = 0; k3.len = 0; k3.data = 0;
    m3.valid = 0; m3.len = 0; m3.data = 0;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1;
    idle_inputs();
    nxt();
    nxt();
    rst = 0;
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [31:0] data;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    bit ok;
    int n;
    logic [31:0] got;
    int tms[$];
    logic [7:0] bs[$];
    int ack_seq[$];
    logic [7:0] sched[$];
    logic lastm, eg, ek, em, w, idle, pk, pm;
    logic [7:0] b;
    int cyc;
    int nb;

    vt[0] = '{3'd0, 32'hAABBCCDD, 0, 32'h0};
    vt[1] = '{3'd7, 32'h44332211, 4, 32'h44332211};
    vt[2] = '{3'd1, 32'h000000E0, 1, 32'h000000E0};
    vt[3] = '{3'd2, 32'h0000F01C, 2, 32'h0000F01C};
    vt[4] = '{3'd3, 32'h99123456, 3, 32'h00123456};
    vt[5] = '{3'd5, 32'hCAFEBABE, 4, 32'hCAFEBABE};
    vt[6] = '{3'd4, 32'h01020304, 4, 32'h01020304};

    idle_inputs();
    do_reset();
    en = 1;
    rdy = 1;

    // reset state
    smp();
    chk("rst_strobe", {31'd0, stb0}, 0);
    chk("rst_byte", {24'd0, byt0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_grant", {31'd0, gnt0}, 0);
    chk("rst_kack", {31'd0, k0.ack}, 0);

    // single kbd packet, exact timing
    nxt();
    k0.valid = 1; k0.len = 2; k0.data = 32'h0000F01C;
    smp();
    chk("t_ack_n", {31'd0, k0.ack}, 1);
    chk("t_stb_n", {31'd0, stb0}, 0);
    nxt();
    k0.valid = 0;
    smp();
    chk("t_stb_n1", {31'd0, stb0}, 1);
    chk("t_byte_n1", {24'd0, byt0}, 32'h1C);
    chk("t_grant", {31'd0, gnt0}, 0);
    nxt();
    smp();
    chk("t_stb_n2", {31'd0, stb0}, 1);
    chk("t_byte_n2", {24'd0, byt0}, 32'hF0);
    nxt();
    smp();
    chk("t_busy_n3", {31'd0, busy0}, 0);
    chk("t_stb_n3", {31'd0, stb0}, 0);
    chk("t_hold_n3", {24'd0, byt0}, 32'hF0);

    // length table
    for (int v = 0; v < 7; v++) begin
      nxt();
      k0.valid = 1;
      k0.len = vt[v].len;
      k0.data = vt[v].data;
      ok = 0;
      for (int c = 0; c < 10 && !ok; c++) begin
        smp();
        if (k0.ack) ok = 1;
        else nxt();
      end
      chk($sformatf("vec%0d_ack", v), {31'd0, ok}, 1);
      n = 0;
      got = 0;
      for (int c = 0; c < 8; c++) begin
        nxt();
        k0.valid = 0;
        smp();
        if (stb0) begin
          if (n < 4) got[8*n +: 8] = byt0;
          n++;
        end
      end
      chk($sformatf("vec%0d_cnt", v), n, vt[v].n);
      chk($sformatf("vec%0d_bytes", v), got,
          vt[v].exp);
    end

    // fifo not ready blocks grant; drop mid-SEND ignored
    nxt();
    rdy = 0;
    k0.valid = 1; k0.len = 4; k0.data = 32'hDDCCBBAA;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      n += int'(k0.ack) + int'(stb0);
      nxt();
    end
    chk("rdy0_quiet", n, 0);
    rdy = 1;
    smp();
    chk("rdy1_ack", {31'd0, k0.ack}, 1);
    n = 0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      nxt();
      k0.valid = 0;
      rdy = 0;
      smp();
      if (stb0) begin
        if (n < 4) got[8*n +: 8] = byt0;
        n++;
      end
    end
    chk("rdy_drop_cnt", n, 4);
    chk("rdy_drop_bytes", got, 32'hDDCCBBAA);
    rdy = 1;

    // both continuously valid: alternation
    do_reset();
    k0.valid = 1; k0.len = 1; k0.data = 32'h0000001C;
    m0.valid = 1; m0.len = 3; m0.data = 32'h00FF0108;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (k0.ack) ack_seq.push_back(0);
      if (m0.ack) ack_seq.push_back(1);
      if (stb0) begin
        bs.push_back(byt0);
        tms.push_back(cyc);
      end
      cyc++;
      nxt();
    end
    idle_inputs();
    chk("alt_nacks", ack_seq.size() >= 4, 1);
    chk("alt_nbytes", bs.size() >= 8, 1);
    if (ack_seq.size() >= 4 && bs.size() >= 8) begin
      chk("alt_order",
          {28'd0, 1'(ack_seq[0]), 1'(ack_seq[1]),
           1'(ack_seq[2]), 1'(ack_seq[3])},
          32'b0101);
      chk("alt_bytes_a", {bs[0], bs[1], bs[2], bs[3]},
          32'h1C0801FF);
      chk("alt_bytes_b", {bs[4], bs[5], bs[6], bs[7]},
          32'h1C0801FF);
      chk("alt_mouse_contig",
          (tms[3] - tms[1] == 2) ? 1 : 0, 1);
    end

    // gap instance: back-to-back kbd packets of len 1
    do_reset();
    k3.valid = 1; k3.len = 1; k3.data = 32'h5A;
    tms.delete();
    for (int c = 0; c < 30; c++) begin
      smp();
      if (stb3) tms.push_back(c);
      nxt();
    end
    k3.valid = 0;
    chk("gap_nstb", tms.size() >= 4, 1);
    if (tms.size() >= 4)
      for (int i = 0; i < 3; i++)
        chk($sformatf("gap_dist%0d", i),
            tms[i+1] - tms[i], 5);

    // reset on the 2nd byte of a 4-byte packet
    do_reset();
    k0.valid = 1; k0.len = 4; k0.data = 32'h04030201;
    smp();
    chk("mr_ack", {31'd0, k0.ack}, 1);
    nxt();
    k0.valid = 0;
    smp();
    chk("mr_b0", {24'd0, byt0}, 32'h01);
    nxt();
    rst = 1;
    smp();
    chk("mr_b1", {24'd0, byt0}, 32'h02);
    nxt();
    rst = 0;
    k0.valid = 1; k0.len = 1; k0.data = 32'h77;
    m0.valid = 1; m0.len = 1; m0.data = 32'h88;
    smp();
    chk("mr_stb", {31'd0, stb0}, 0);
    chk("mr_busy", {31'd0, busy0}, 0);
    chk("mr_byte", {24'd0, byt0}, 0);
    chk("mr_grant", {31'd0, gnt0}, 0);
    chk("mr_tie_kack", {31'd0, k0.ack}, 1);
    chk("mr_tie_mack", {31'd0, m0.ack}, 0);
    nxt();
    idle_inputs();

    // randomised traffic against a byte-queue model
    do_reset();
    lastm = 1;
    eg = 0;
    pk = 0;
    pm = 0;
    sched.delete();
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (pk) begin
        k0.valid = 1'($urandom_range(1));
        k0.len = 3'($urandom_range(7));
        k0.data = $urandom;
      end else if (!k0.valid) begin
        if ($urandom_range(2) == 0) begin
          k0.valid = 1;
          k0.len = 3'($urandom_range(7));
          k0.data = $urandom;
        end
      end else if ($urandom_range(15) == 0)
        k0.valid = 0;
      if (pm) begin
        m0.valid = 1'($urandom_range(1));
        m0.len = 3'($urandom_range(7));
        m0.data = $urandom;
      end else if (!m0.valid) begin
        if ($urandom_range(2) == 0) begin
          m0.valid = 1;
          m0.len = 3'($urandom_range(7));
          m0.data = $urandom;
        end
      end else if ($urandom_range(15) == 0)
        m0.valid = 0;
      en = ($urandom_range(7) != 0);
      rdy = ($urandom_range(3) != 0);
      smp();
      idle = (sched.size() == 0);
      chk("rnd_busy", {31'd0, busy0}, {31'd0, !idle});
      chk("rnd_grant", {31'd0, gnt0}, {31'd0, eg});
      if (idle) begin
        chk("rnd_stb0", {31'd0, stb0}, 0);
      end else begin
        b = sched.pop_front();
        chk("rnd_stb1", {31'd0, stb0}, 1);
        chk("rnd_byte", {24'd0, byt0}, {24'd0, b});
      end
      ek = 0;
      em = 0;
      if (idle && en && rdy && (k0.valid || m0.valid)) begin
        w = (k0.valid && m0.valid) ? !lastm : m0.valid;
        lastm = w;
        eg = w;
        ek = !w;
        em = w;
        nb = w ? int'(m0.len) : int'(k0.len);
        if (nb > 4) nb = 4;
        for (int i = 0; i < nb; i++)
          sched.push_back(w ? m0.data[8*i +: 8]
                            : k0.data[8*i +: 8]);
      end
      chk("rnd_kack", {31'd0, k0.ack}, {31'd0, ek});
      chk("rnd_mack", {31'd0, m0.ack}, {31'd0, em});
      pk = ek;
      pm = em;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
